// File: rtl/chip_mux_checker.sv
// -----------------------------------------------------------------------------
// chip_mux_checker
//
// Exhaustive tester for multiplexer-family DIP chips (74153 dual 4:1,
// 74151 8:1 with inverted output, 74157 quad 2:1). A single vector counter
// V sweeps every combination of select lines, data inputs and active-low
// strobes. Each vector is driven, allowed to settle, then the synchronised
// device outputs are compared against a built-in mux model:
//   expected Y[s] = G_n[s] ? 0 : D_s[Sel],   expected W[s] = ~expected Y[s]
//
// Vector layout (V[VEC_W-1:0]):
//   V[SEL_BITS-1:0]          -> Drv_Sel
//   V[SEL_BITS +: DW]        -> Drv_D   (section s uses [s*2**SEL_BITS +: 2**SEL_BITS])
//   V[VEC_W-1 -: NUM_SECTIONS] -> Drv_G_n
//
// Ports:
//   Clk        system clock
//   Reset      asynchronous active-low reset
//   Run        start request, a test starts on its rising edge
//   Chip_Y     device Y outputs, one per section
//   Chip_W     device inverted outputs (only checked when HAS_INV_OUT=1)
//   DISP_RSLT  result display enable for RSLT
//   Drv_Sel    select lines to the device
//   Drv_D      data inputs to the device
//   Drv_G_n    active-low strobes to the device
//   Done       test complete
//   RSLT       Done & DISP_RSLT & all sections passed
//   Sect_Pass  per-section pass flags
//   Fail_Vec   first failing vector
//   Err_Cnt    saturating count of failing vectors
//
// Each vector costs SETTLE_CYCLES+2 cycles (DRIVE, SETTLE_CYCLES x SETTLE,
// CHECK). SETTLE_CYCLES must lie in 3..255 so that the 2-flop synchronisers
// have flushed the new device response before CHECK samples it.
// -----------------------------------------------------------------------------
module chip_mux_checker #(
  parameter  int SEL_BITS      = 2,
  parameter  int NUM_SECTIONS  = 2,
  parameter  int HAS_INV_OUT   = 0,
  parameter  int SETTLE_CYCLES = 4,
  parameter  int ERR_W         = 16,
  localparam int NIN           = 2**SEL_BITS,
  localparam int DW            = NUM_SECTIONS*NIN,
  localparam int VEC_W         = SEL_BITS + DW + NUM_SECTIONS
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    Run,
  input  logic [NUM_SECTIONS-1:0] Chip_Y,
  input  logic [NUM_SECTIONS-1:0] Chip_W,
  input  logic                    DISP_RSLT,
  output logic [SEL_BITS-1:0]     Drv_Sel,
  output logic [DW-1:0]           Drv_D,
  output logic [NUM_SECTIONS-1:0] Drv_G_n,
  output logic                    Done,
  output logic                    RSLT,
  output logic [NUM_SECTIONS-1:0] Sect_Pass,
  output logic [VEC_W-1:0]        Fail_Vec,
  output logic [ERR_W-1:0]        Err_Cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t                  state;
  logic [VEC_W-1:0]        vec;
  logic [7:0]              settle_cnt;
  logic                    run_q;
  logic [NUM_SECTIONS-1:0] y_meta, y_sync;
  logic [NUM_SECTIONS-1:0] w_meta, w_sync;

  // Vector fields as seen by the model; V is stable from DRIVE through CHECK,
  // so decoding the counter directly matches what the device is being driven.
  logic [SEL_BITS-1:0]     v_sel;
  logic [DW-1:0]           v_d;
  logic [NUM_SECTIONS-1:0] v_gn;
  logic [NUM_SECTIONS-1:0] exp_y;
  logic [NUM_SECTIONS-1:0] mismatch;
  logic                    run_rise;

  assign v_sel    = vec[SEL_BITS-1:0];
  assign v_d      = vec[SEL_BITS +: DW];
  assign v_gn     = vec[VEC_W-1 -: NUM_SECTIONS];
  assign run_rise = Run & ~run_q;

  // Reference mux model and per-section compare.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    exp_y    = '0;
    mismatch = '0;
    for (int s = 0; s < NUM_SECTIONS; s++) begin
      exp_y[s]    = v_gn[s] ? 1'b0 : v_d[s*NIN + int'(v_sel)];
      mismatch[s] = (y_sync[s] != exp_y[s]);
      if (HAS_INV_OUT != 0) begin
        mismatch[s] = mismatch[s] | (w_sync[s] != ~exp_y[s]);
      end
    end
  end

  // Pass is only shown once the sweep has finished; Sect_Pass is all ones
  // during a test, so Done gates RSLT low until the end.
  assign RSLT = Done & DISP_RSLT & (&Sect_Pass);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state      <= S_IDLE;
      vec        <= '0;
      settle_cnt <= '0;
      run_q      <= 1'b0;
      y_meta     <= '0;
      y_sync     <= '0;
      w_meta     <= '0;
      w_sync     <= '0;
      Drv_Sel    <= '0;
      Drv_D      <= '0;
      Drv_G_n    <= '1;
      Done       <= 1'b0;
      Sect_Pass  <= '0;
      Fail_Vec   <= '0;
      Err_Cnt    <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      run_q  <= Run;
      y_meta <= Chip_Y;
      y_sync <= y_meta;
      w_meta <= Chip_W;
      w_sync <= w_meta;

      case (state)
        S_IDLE, S_DONE: begin
          if (state == S_DONE) begin
            Done <= 1'b1;
          end
          // Only a fresh rising edge starts a test, so Run held high after
          // completion does not loop the sweep.
          if (run_rise) begin
            vec       <= '0;
            Sect_Pass <= '1;
            Err_Cnt   <= '0;
            Fail_Vec  <= '0;
            Done      <= 1'b0;
            state     <= S_DRIVE;
          end
        end

        S_DRIVE: begin
          Drv_Sel    <= v_sel;
          Drv_D      <= v_d;
          Drv_G_n    <= v_gn;
          settle_cnt <= 8'(SETTLE_CYCLES - 1);
          state      <= S_SETTLE;
        end

        S_SETTLE: begin
          if (settle_cnt == '0) begin
            state <= S_CHECK;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end

        S_CHECK: begin
          if (|mismatch) begin
            Sect_Pass <= Sect_Pass & ~mismatch;
            if (Err_Cnt != '1) begin
              Err_Cnt <= Err_Cnt + 1'b1;
            end
            // The counter saturates rather than wrapping, so zero means no
            // failure has been seen yet in this sweep.
            if (Err_Cnt == '0) begin
              Fail_Vec <= vec;
            end
          end
          if (vec == '1) begin
            // Park the device disabled with quiet inputs while results are held.
            Drv_Sel <= '0;
            Drv_D   <= '0;
            Drv_G_n <= '1;
            state   <= S_DONE;
          end else begin
            vec   <= vec + 1'b1;
            state <= S_DRIVE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chip_mux_checker.sv
// -----------------------------------------------------------------------------
// tb_chip_mux_checker
//
// Four checker instances run side by side, each wired to its own behavioural
// device model:
//   0: ideal 74153
//   1: section 0 Y stuck at 0
//   2: section 1 Y inverted while its strobe is active
//   3: both Y stuck at 1, checker built with ERR_W=4
// When a test is started the expected end-of-test result for each instance is
// pushed into a per-instance queue; a monitor pops and compares on each rising
// Done. Expected results come from a plain sweep over all 4096 vectors using
// arithmetic on the vector number.
// -----------------------------------------------------------------------------
module tb_chip_mux_checker;

  localparam int NDUT     = 4;
  localparam int NVEC     = 4096;
  localparam int TEST_LAT = NVEC*(4+2) + 1;

  typedef struct {
    int         start;
    logic [1:0] pass;
    logic [11:0] fv;
    int         errs;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic run = 1'b0;
  logic disp = 1'b1;
  int   cyc = 0;

  logic [1:0]  chip_y    [NDUT];
  logic [1:0]  chip_w    [NDUT];
  logic [1:0]  drv_sel   [NDUT];
  logic [7:0]  drv_d     [NDUT];
  logic [1:0]  drv_g_n   [NDUT];
  logic [NDUT-1:0] done;
  logic [NDUT-1:0] rslt;
  logic [1:0]  sect_pass [NDUT];
  logic [11:0] fail_vec  [NDUT];
  logic [15:0] err_cnt   [NDUT];

  exp_t exp_q [NDUT][$];
  exp_t ref_res [NDUT];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural device: a healthy dual 4:1 mux with an optional planted fault.
  function automatic logic [1:0] dev_y(int mode, logic [1:0] sel, logic [7:0] d,
                                       logic [1:0] gn);
    logic [1:0] y;
    for (int s = 0; s < 2; s++) y[s] = gn[s] ? 1'b0 : d[s*4 + int'(sel)];
    case (mode)
      1: y[0] = 1'b0;
      2: if (!gn[1]) y[1] = ~y[1];
      3: y = 2'b11;
      default: ;
    endcase
    return y;
  endfunction

  // Reference: what the tester should report after sweeping every vector.
  function automatic exp_t ref_model(int mode);
    exp_t r;
    int   sat;
    int   sel, dat, gn;
    logic first;
    logic bad;
    logic [1:0] want, got;
    r.start = 0;
    r.pass  = 2'b11;
    r.fv    = '0;
    r.errs  = 0;
    sat     = (mode == 3) ? 15 : 65535;
    first   = 1'b1;
    for (int v = 0; v < NVEC; v++) begin
      sel = v % 4;
      dat = (v / 4) % 256;
      gn  = v / 1024;
      for (int s = 0; s < 2; s++)
        want[s] = (((gn >> s) & 1) != 0) ? 1'b0 : 1'(((dat >> (4*s + sel)) & 1));
      got = dev_y(mode, 2'(sel), 8'(dat), 2'(gn));
      bad = 1'b0;
      for (int s = 0; s < 2; s++) begin
        if (want[s] != got[s]) begin
          r.pass[s] = 1'b0;
          bad = 1'b1;
        end
      end
      if (bad) begin
        if (first) begin
          r.fv  = 12'(v);
          first = 1'b0;
        end
        if (r.errs < sat) r.errs++;
      end
    end
    return r;
  endfunction

  for (genvar i = 0; i < NDUT; i++) begin : g_dut
    localparam int EW = (i == 3) ? 4 : 16;
    logic [EW-1:0] ec;

    assign chip_y[i]  = dev_y(i, drv_sel[i], drv_d[i], drv_g_n[i]);
    assign chip_w[i]  = ~chip_y[i];
    assign err_cnt[i] = 16'(ec);

    chip_mux_checker #(
      .SEL_BITS(2), .NUM_SECTIONS(2), .HAS_INV_OUT(0),
      .SETTLE_CYCLES(4), .ERR_W(EW)
    ) u_dut (
      .Clk(clk), .Reset(rst_n), .Run(run),
      .Chip_Y(chip_y[i]), .Chip_W(chip_w[i]), .DISP_RSLT(disp),
      .Drv_Sel(drv_sel[i]), .Drv_D(drv_d[i]), .Drv_G_n(drv_g_n[i]),
      .Done(done[i]), .RSLT(rslt[i]), .Sect_Pass(sect_pass[i]),
      .Fail_Vec(fail_vec[i]), .Err_Cnt(ec)
    );
  end

  task automatic check(string name, int act, int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, req, req, cyc);
    end
  endtask

  task automatic check_reset_values();
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("rst_sel[%0d]", i),  int'(drv_sel[i]),   0);
      check($sformatf("rst_d[%0d]", i),    int'(drv_d[i]),     0);
      check($sformatf("rst_gn[%0d]", i),   int'(drv_g_n[i]),   3);
      check($sformatf("rst_done[%0d]", i), int'(done[i]),      0);
      check($sformatf("rst_rslt[%0d]", i), int'(rslt[i]),      0);
      check($sformatf("rst_pass[%0d]", i), int'(sect_pass[i]), 0);
      check($sformatf("rst_fv[%0d]", i),   int'(fail_vec[i]),  0);
      check($sformatf("rst_err[%0d]", i),  int'(err_cnt[i]),   0);
    end
  endtask

  // Expected result for a test whose Run edge is seen at the next posedge.
  task automatic push_expected();
    exp_t e;
    for (int i = 0; i < NDUT; i++) begin
      e = ref_res[i];
      e.start = cyc + 1;
      exp_q[i].push_back(e);
    end
  endtask

  task automatic wait_done(int budget);
    int n;
    n = 0;
    while (!(&done) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", int'(&done), 1);
    @(negedge clk);
  endtask

  // Monitor: scores each completed test against the queued expectation.
  logic [NDUT-1:0] done_prev = '0;
  always @(negedge clk) begin : monitor
    exp_t e;
    for (int i = 0; i < NDUT; i++) begin
      if (done[i] && !done_prev[i]) begin
        if (exp_q[i].size() == 0) begin
          check($sformatf("unexpected_done[%0d]", i), 1, 0);
        end else begin
          e = exp_q[i].pop_front();
          check($sformatf("latency[%0d]", i),  cyc - e.start,       TEST_LAT);
          check($sformatf("pass[%0d]", i),     int'(sect_pass[i]),  int'(e.pass));
          check($sformatf("fail_vec[%0d]", i), int'(fail_vec[i]),   int'(e.fv));
          check($sformatf("err_cnt[%0d]", i),  int'(err_cnt[i]),    e.errs);
          check($sformatf("rslt[%0d]", i),     int'(rslt[i]),
                int'(disp & (&e.pass)));
          check($sformatf("idle_gn[%0d]", i),  int'(drv_g_n[i]),    3);
          check($sformatf("idle_sel[%0d]", i), int'(drv_sel[i]),    0);
          check($sformatf("idle_d[%0d]", i),   int'(drv_d[i]),      0);
        end
      end
    end
    done_prev <= done;
  end

  initial begin
    for (int i = 0; i < NDUT; i++) ref_res[i] = ref_model(i);

    // Reset state.
    #1 rst_n = 1'b0;
    #2 check_reset_values();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Test 1: full sweep; a Run edge at cycle 100 must not restart it.
    run = 1'b1;
    push_expected();
    repeat (50) @(negedge clk);
    run = 1'b0;
    repeat (50) @(negedge clk);
    run = 1'b1;
    wait_done(TEST_LAT + 200);

    // RSLT follows the display enable.
    disp = 1'b0;
    #1;
    for (int i = 0; i < NDUT; i++)
      check($sformatf("rslt_nodisp[%0d]", i), int'(rslt[i]), 0);
    @(negedge clk);
    disp = 1'b1;
    #1 check("rslt_disp[0]", int'(rslt[0]), 1);

    // Test 2: fresh start after Done clears results, then aborted by reset.
    @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    run = 1'b1;
    push_expected();
    @(negedge clk);
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("restart_done[%0d]", i), int'(done[i]),    0);
      check($sformatf("restart_err[%0d]", i),  int'(err_cnt[i]), 0);
    end
    repeat (4998) @(negedge clk);
    #2 rst_n = 1'b0;
    for (int i = 0; i < NDUT; i++) exp_q[i].delete();
    run = 1'b0;
    #1 check_reset_values();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Test 3: full sweep after the abort, with Run then held high.
    run = 1'b1;
    push_expected();
    wait_done(TEST_LAT + 200);
    repeat (200) @(negedge clk);
    check("held_run_done", int'(done), 4'hF);
    check("held_run_err1", int'(err_cnt[1]), ref_res[1].errs);
    check("held_run_q", exp_q[0].size(), 0);
    run = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
